// File: rtl/system.sv
// Wheel quadrature counters, lighthouse sampling and an SPI slave command interface.
// Define SERVO_EN to build the servo PWM generator and command 0x40.
module system #(
  parameter int NUM_LH_SENSORS = 3,
  parameter int CLK_HZ         = 16000000
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [7:0]                WHEEL_SENSOR,
  input  logic [NUM_LH_SENSORS-1:0] LH_SENSOR,
  input  logic                      SSEL,
  input  logic                      SCLK,
  input  logic                      MOSI,
  output logic                      MISO,
  output logic                      SERVO
);

  localparam logic [7:0] CMD_LH    = 8'h20;
  localparam logic [7:0] CMD_RD    = 8'h30;
  localparam logic [7:0] CMD_CLR   = 8'h31;
  localparam logic [7:0] CMD_SERVO = 8'h40;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_CMD,
    SPI_DATA
  } spi_state_e;

  if (CLK_HZ < 1000000) begin : g_clk_check
    $error("system: CLK_HZ must be at least 1 MHz");
  end

  // Input synchronisers
  logic [7:0]                whl_s1_q, whl_s2_q, whl_prev_q;
  logic [NUM_LH_SENSORS-1:0] lh_s1_q, lh_s2_q;
  logic [2:0]                spi_s1_q, spi_s2_q;
  logic                      ssel_prev_q, sclk_prev_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      whl_s1_q    <= '0;
      whl_s2_q    <= '0;
      whl_prev_q  <= '0;
      lh_s1_q     <= '0;
      lh_s2_q     <= '0;
      spi_s1_q    <= '0;
      spi_s2_q    <= '0;
      ssel_prev_q <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      whl_s1_q    <= WHEEL_SENSOR;
      whl_s2_q    <= whl_s1_q;
      whl_prev_q  <= whl_s2_q;
      lh_s1_q     <= LH_SENSOR;
      lh_s2_q     <= lh_s1_q;
      spi_s1_q    <= {SSEL, SCLK, MOSI};
      spi_s2_q    <= spi_s1_q;
      ssel_prev_q <= spi_s2_q[2];
      sclk_prev_q <= spi_s2_q[1];
    end
  end

  // Edge detectors start low after reset so a select held low never looks like a fresh frame.
  logic ssel_s, sclk_s, mosi_s;
  logic ssel_fall, sclk_rise, sclk_fall;

  assign ssel_s    = spi_s2_q[2];
  assign sclk_s    = spi_s2_q[1];
  assign mosi_s    = spi_s2_q[0];
  assign ssel_fall = ~ssel_s & ssel_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  function automatic logic [1:0] gray_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  function automatic logic signed [31:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    diff = gray_pos(cur) - gray_pos(prev);
    case (diff)
      2'd1:    return 32'sd1;
      2'd3:    return -32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  // Wheel counters and readout snapshot
  logic signed [31:0] cnt_q [4];
  logic signed [31:0] cnt_d [4];
  logic        [31:0] snap_q [4];
  logic               snap_en, clr_en;

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      cnt_d[w] = cnt_q[w] + quad_step(whl_prev_q[2*w +: 2], whl_s2_q[2*w +: 2]);
      if (clr_en) begin
        cnt_d[w] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      for (int w = 0; w < 4; w++) begin
        cnt_q[w]  <= '0;
        snap_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < 4; w++) begin
        cnt_q[w] <= cnt_d[w];
        if (snap_en) begin
          snap_q[w] <= cnt_q[w];
        end
      end
    end
  end

  // SPI slave
  spi_state_e spi_state_q, spi_state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       miso_q, miso_d;
  logic [7:0] rx_byte, cur_cmd, next_tx;
  logic [31:0] rd_word;
`ifdef SERVO_EN
  logic [7:0] servo_lo_q, servo_lo_d;
  logic       servo_wr;
`endif

  // Byte to present after the one completing now; the command byte reads live counters
  // because the snapshot is only being captured on this same edge.
  always_comb begin
    rx_byte = {rx_sh_q, mosi_s};
    cur_cmd = (spi_state_q == SPI_CMD) ? rx_byte : cmd_q;
    rd_word = (spi_state_q == SPI_CMD) ? cnt_q[byte_cnt_q[3:2]] : snap_q[byte_cnt_q[3:2]];
    next_tx = 8'h00;
    case (cur_cmd)
      CMD_RD: begin
        if (byte_cnt_q < 5'd16) begin
          next_tx = rd_word[{byte_cnt_q[1:0], 3'b000} +: 8];
        end
      end
      CMD_LH: begin
        if (byte_cnt_q == 5'd0) begin
          next_tx = 8'(lh_s2_q);
        end
      end
      default: next_tx = 8'h00;
    endcase
  end

  always_comb begin
    spi_state_d = spi_state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_sh_d     = rx_sh_q;
    cmd_d       = cmd_q;
    tx_sh_d     = tx_sh_q;
    miso_d      = miso_q;
    snap_en     = 1'b0;
    clr_en      = 1'b0;
`ifdef SERVO_EN
    servo_lo_d  = servo_lo_q;
    servo_wr    = 1'b0;
`endif
    if (ssel_s) begin
      spi_state_d = SPI_IDLE;
      miso_d      = 1'b0;
    end else if (spi_state_q == SPI_IDLE) begin
      if (ssel_fall) begin
        spi_state_d = SPI_CMD;
        bit_cnt_d   = '0;
        byte_cnt_d  = '0;
        cmd_d       = '0;
        tx_sh_d     = '0;
        miso_d      = 1'b0;
      end
    end else if (sclk_rise) begin
      rx_sh_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        tx_sh_d = next_tx;
        if (byte_cnt_q != 5'd31) begin
          byte_cnt_d = byte_cnt_q + 5'd1;
        end
        if (spi_state_q == SPI_CMD) begin
          spi_state_d = SPI_DATA;
          cmd_d       = rx_byte;
          snap_en     = (rx_byte == CMD_RD);
          clr_en      = (rx_byte == CMD_CLR);
        end
`ifdef SERVO_EN
        else if (cmd_q == CMD_SERVO) begin
          if (byte_cnt_q == 5'd1) begin
            servo_lo_d = rx_byte;
          end
          if (byte_cnt_q == 5'd2) begin
            servo_wr = 1'b1;
          end
        end
`endif
      end
    end else if (sclk_fall) begin
      miso_d  = tx_sh_q[7];
      tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      spi_state_q <= SPI_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      rx_sh_q     <= '0;
      cmd_q       <= '0;
      tx_sh_q     <= '0;
      miso_q      <= 1'b0;
    end else begin
      spi_state_q <= spi_state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_sh_q     <= rx_sh_d;
      cmd_q       <= cmd_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
    end
  end

  assign MISO = miso_q;

`ifdef SERVO_EN
  localparam int CYC_US    = CLK_HZ / 1000000;
  localparam int PW        = (CYC_US > 1) ? $clog2(CYC_US) : 1;
  localparam int PERIOD_US = 20000;

  function automatic logic [11:0] clamp_us(input logic [15:0] v);
    if (v < 16'd500) begin
      return 12'd500;
    end else if (v > 16'd2500) begin
      return 12'd2500;
    end
    return v[11:0];
  endfunction

  logic [PW-1:0] presc_q;
  logic [14:0]   us_q;
  logic [11:0]   width_q, act_w_q;
  logic          servo_q;

  // Width written over SPI is only adopted at a period boundary to keep pulses whole.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      servo_lo_q <= '0;
      presc_q    <= '0;
      us_q       <= '0;
      width_q    <= 12'd1500;
      act_w_q    <= 12'd1500;
      servo_q    <= 1'b0;
    end else begin
      servo_lo_q <= servo_lo_d;
      if (servo_wr) begin
        width_q <= clamp_us({rx_byte, servo_lo_q});
      end
      if (presc_q == PW'(CYC_US - 1)) begin
        presc_q <= '0;
        if (us_q == 15'(PERIOD_US - 1)) begin
          us_q    <= '0;
          act_w_q <= width_q;
        end else begin
          us_q <= us_q + 15'd1;
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      servo_q <= (us_q < {3'b000, act_w_q});
    end
  end

  assign SERVO = servo_q;
`else
  assign SERVO = 1'b0;
`endif

endmodule

// File: tb/tb_system.sv
// Scoreboarded SPI bench for system: table of wheel moves with expected counters, plus
// hand sequences for snapshot isolation, clear races, aborts, reset and (optionally) servo.
module tb_system;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [7:0] WHEEL_SENSOR = 8'h00;
  logic [2:0] LH_SENSOR = 3'b000;
  logic       SSEL = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic       SERVO;

  system #(.NUM_LH_SENSORS(3), .CLK_HZ(1000000)) dut (
    .CLK(CLK), .RESETN(RESETN), .WHEEL_SENSOR(WHEEL_SENSOR), .LH_SENSOR(LH_SENSOR),
    .SSEL(SSEL), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SERVO(SERVO)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int wpos[4];
  int model[4];
  int cyc = 0;
  logic [7:0] sb_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int              wheel;
    int              steps;
    bit              jump;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(int w, int s, bit j, int e0, int e1, int e2, int e3);
    vec_t v;
    v.wheel = w; v.steps = s; v.jump = j;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  function automatic logic [1:0] gray(int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic step_set(input int w, input int dir);
    wpos[w] = (wpos[w] + dir) & 3;
    model[w] += dir;
    WHEEL_SENSOR[2*w +: 2] = gray(wpos[w]);
  endtask

  task automatic step(input int w, input int n);
    int dir;
    dir = (n < 0) ? -1 : 1;
    for (int k = 0; k < ((n < 0) ? -n : n); k++) begin
      step_set(w, dir);
      clk_n(4);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input string name, input bit do_step);
    logic [7:0] rx;
    for (int i = 7; i >= 0; i--) begin
      MOSI = tx[i];
      clk_n(4);
      rx[i] = MISO;
      SCLK = 1'b1;
      if (do_step && i == 0) step_set(0, 1);
      clk_n(4);
      SCLK = 1'b0;
    end
    if (sb_q.size() == 0) check({name, "_sb_empty"}, 32'd1, 32'd0);
    else check(name, {24'h0, rx}, {24'h0, sb_q.pop_front()});
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input string name,
                      input bit do_step = 1'b0);
    sb_q.push_back(exp);
    spi_byte(tx, name, do_step);
  endtask

  task automatic frame_begin();
    SSEL = 1'b0;
    clk_n(4);
  endtask

  task automatic frame_end();
    clk_n(2);
    SSEL = 1'b1;
    clk_n(6);
  endtask

  task automatic read_counters(input logic [3:0][31:0] e, input string name);
    logic [31:0] wd;
    logic [7:0]  eb;
    frame_begin();
    xfer(8'h30, 8'h00, {name, "_cmd"});
    for (int j = 0; j < 18; j++) begin
      wd = e[j >> 2];
      eb = (j < 16) ? wd[8*(j & 3) +: 8] : 8'h00;
      xfer(8'h00, eb, $sformatf("%s_b%0d", name, j));
    end
    frame_end();
  endtask

  task automatic read_model(input string name);
    logic [3:0][31:0] e;
    for (int w = 0; w < 4; w++) e[w] = model[w];
    read_counters(e, name);
  endtask

  task automatic wait_servo(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (SERVO === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0, t1, t2, hi;
    for (int w = 0; w < 4; w++) begin wpos[w] = 0; model[w] = 0; end

    vecs[0] = mk(0, 100, 1'b0, 100, 0, 0, 0);
    vecs[1] = mk(2, -48, 1'b0, 100, 0, -48, 0);
    vecs[2] = mk(1, 0, 1'b1, 100, 0, -48, 0);
    vecs[3] = mk(1, 10, 1'b0, 100, 10, -48, 0);
    vecs[4] = mk(3, -1, 1'b0, 100, 10, -48, -1);

    clk_n(5);
    check("reset_miso", {31'h0, MISO}, 32'd0);
    check("reset_servo", {31'h0, SERVO}, 32'd0);
    RESETN = 1'b1;
    clk_n(5);
    read_model("reset_cnt");

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].jump) begin
        WHEEL_SENSOR[2*vecs[i].wheel +: 2] = 2'b11;
        clk_n(4);
        WHEEL_SENSOR[2*vecs[i].wheel +: 2] = 2'b00;
        clk_n(4);
      end else begin
        step(vecs[i].wheel, vecs[i].steps);
      end
      read_counters(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Clear command
    frame_begin();
    xfer(8'h31, 8'h00, "clr_cmd");
    xfer(8'h00, 8'h00, "clr_b0");
    frame_end();
    for (int w = 0; w < 4; w++) model[w] = 0;
    read_model("after_clr");

    // Movement during a readout lands in the live counter only
    step(0, 5);
    frame_begin();
    xfer(8'h30, 8'h00, "snap_cmd");
    step(0, 256);
    for (int j = 0; j < 16; j++)
      xfer(8'h00, (j == 0) ? 8'h05 : 8'h00, $sformatf("snap_b%0d", j));
    frame_end();
    read_model("snap_live");

    // Step landing on the same edge as the clear loses
    frame_begin();
    xfer(8'h31, 8'h00, "race_cmd", 1'b1);
    frame_end();
    for (int w = 0; w < 4; w++) model[w] = 0;
    read_model("race_clr");

    // Lighthouse and unknown command
    LH_SENSOR = 3'b101;
    clk_n(4);
    frame_begin();
    xfer(8'h20, 8'h00, "lh_cmd");
    xfer(8'h00, 8'h05, "lh_b0");
    xfer(8'h00, 8'h00, "lh_b1");
    frame_end();
    frame_begin();
    xfer(8'h55, 8'h00, "unk_cmd");
    xfer(8'h00, 8'h00, "unk_b0");
    xfer(8'h00, 8'h00, "unk_b1");
    frame_end();

    // Partial byte then SSEL high; next frame must decode cleanly
    frame_begin();
    for (int i = 7; i >= 4; i--) begin
      MOSI = (i == 5 || i == 4) ? 1'b1 : 1'b0;
      clk_n(4); SCLK = 1'b1; clk_n(4); SCLK = 1'b0;
    end
    frame_end();
    frame_begin();
    xfer(8'h20, 8'h00, "abort_lh_cmd");
    xfer(8'h00, 8'h05, "abort_lh_b0");
    frame_end();

    // Reset in the middle of a readout
    step(0, 2); step(1, 2); step(3, 1);
    frame_begin();
    xfer(8'h30, 8'h00, "rst_cmd");
    xfer(8'h00, 8'h02, "rst_b0");
    xfer(8'h00, 8'h00, "rst_b1");
    xfer(8'h00, 8'h00, "rst_b2");
    xfer(8'h00, 8'h00, "rst_b3");
    MOSI = 1'b1; clk_n(4); SCLK = 1'b1; clk_n(4);
    RESETN = 1'b0;
    clk_n(2);
    check("rst_mid_miso", {31'h0, MISO}, 32'd0);
    check("rst_mid_servo", {31'h0, SERVO}, 32'd0);
    SCLK = 1'b0;
    RESETN = 1'b1;
    clk_n(4);
    xfer(8'hA5, 8'h00, "post_rst_miso");
    frame_end();
    for (int w = 0; w < 4; w++) model[w] = 0;
    read_model("post_rst_cnt");

`ifdef SERVO_EN
    frame_begin();
    xfer(8'h40, 8'h00, "srv_abort_cmd");
    xfer(8'h08, 8'h00, "srv_abort_b0");
    frame_end();
    wait_servo(1'b0, 25000, ok); check("srv_to0", {31'h0, ok}, 32'd1);
    wait_servo(1'b1, 25000, ok); check("srv_to1", {31'h0, ok}, 32'd1);
    t0 = cyc;
    wait_servo(1'b0, 3000, ok); check("srv_to2", {31'h0, ok}, 32'd1);
    check("srv_w1500", cyc - t0, 32'd1500);

    frame_begin();
    xfer(8'h40, 8'h00, "srv_cmd");
    xfer(8'h08, 8'h00, "srv_b0");
    xfer(8'h07, 8'h00, "srv_b1");
    frame_end();
    wait_servo(1'b0, 25000, ok); check("srv_to3", {31'h0, ok}, 32'd1);
    wait_servo(1'b1, 25000, ok); check("srv_to4", {31'h0, ok}, 32'd1);
    t0 = cyc;
    wait_servo(1'b0, 3000, ok); check("srv_to5", {31'h0, ok}, 32'd1);
    t1 = cyc;
    check("srv_w1800", t1 - t0, 32'd1800);
    frame_begin();
    xfer(8'h40, 8'h00, "srv_max_cmd");
    xfer(8'hFF, 8'h00, "srv_max_b0");
    xfer(8'hFF, 8'h00, "srv_max_b1");
    frame_end();
    wait_servo(1'b1, 25000, ok); check("srv_to6", {31'h0, ok}, 32'd1);
    t2 = cyc;
    check("srv_low", t2 - t1, 32'd18200);
    wait_servo(1'b0, 3000, ok); check("srv_to7", {31'h0, ok}, 32'd1);
    check("srv_w2500", cyc - t2, 32'd2500);
`else
    frame_begin();
    xfer(8'h40, 8'h00, "srv_off_cmd");
    xfer(8'h08, 8'h00, "srv_off_b0");
    xfer(8'h07, 8'h00, "srv_off_b1");
    frame_end();
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      if (SERVO !== 1'b0) hi++;
      clk_n(1);
    end
    check("srv_off_level", hi, 32'd0);
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
